// File: rtl/display_pkg.sv
// Shared definitions for the 3-digit 7-segment scan controller:
// FSM encoding, digit count, anode patterns and the segment decode table.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 3;

  // Active-low one-hot anodes; unused anodes [7:3] held high.
  localparam logic [7:0] ANODE_UNITS    = 8'hFE;
  localparam logic [7:0] ANODE_TENS     = 8'hFD;
  localparam logic [7:0] ANODE_HUNDREDS = 8'hFB;
  localparam logic [7:0] SEG_BLANK      = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low; dp stays off.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one bit per step.
// start loads the binary value; each step does add-3-if->=5 on every BCD
// nibble then shifts left. done is high during the eighth (final) step, so
// bcd holds the finished result from the following cycle.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  din,
  input  logic        step,
  output logic [11:0] bcd,
  output logic        done
);

  // [19:8] BCD hundreds/tens/units, [7:0] remaining binary bits
  logic [19:0] shreg;
  logic [19:0] adj;
  logic [3:0]  cnt;

  // Add-3 correction on each BCD nibble ahead of the shift.
  always_comb begin
    adj = shreg;
    if (shreg[11:8]  >= 4'd5) adj[11:8]  = shreg[11:8]  + 4'd3;
    if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
  end

  // Load on start, otherwise shift one bit per step until eight are done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= {12'b0, din};
      cnt   <= '0;
    end else if (step && cnt != 4'd8) begin
      shreg <= {adj[18:0], 1'b0};
      cnt   <= cnt + 4'd1;
    end
  end

  assign bcd  = shreg[19:8];
  assign done = step && (cnt == 4'd7);

endmodule

// File: rtl/display_scan_ctrl.sv
// Display sequencer: accepts an 8-bit result, converts it to BCD, commits
// the three digits atomically and multiplexes them onto the shared pins.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading-zero hundreds
// and tens slots.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | ready for a new value (Listo high)
//   ST_CONV   | double-dabble iterating, one bit per cycle
//   ST_COMMIT | copy finished BCD into the displayed digit regs
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int DATA_W   = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Valor,
  input  logic              Valido,
  output logic              Listo,
  output logic              Ocupado,
  output logic [7:0]        Displays,
  output logic [7:0]        Segmentos
);

  localparam int PW = $clog2(SCAN_DIV);

  state_t      state, state_nx;
  logic        conv_start, conv_step, conv_done, commit;
  logic [11:0] bcd;
  logic [3:0]  dig_c, dig_b, dig_a;
  logic [PW-1:0] presc;
  logic [1:0]  scan_idx;
  logic [7:0]  anode_nx, seg_nx;
  logic [3:0]  nib;
  logic        blank;

  bin2bcd_seq u_bcd (
    .Clk   (Clk),
    .Reset (Reset),
    .start (conv_start),
    .din   (Valor),
    .step  (conv_step),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // State register; Ocupado registered alongside so it tracks state != IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_IDLE;
      Ocupado <= 1'b0;
    end else begin
      state   <= state_nx;
      Ocupado <= (state_nx != ST_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (Valido && Listo) state_nx = ST_CONV;
      ST_CONV:   if (conv_done)       state_nx = ST_COMMIT;
      ST_COMMIT:                      state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake and datapath controls.
  always_comb begin
    Listo      = (state == ST_IDLE) && !Reset;
    conv_start = (state == ST_IDLE) && Valido && Listo;
    conv_step  = (state == ST_CONV);
    commit     = (state == ST_COMMIT);
  end

  // Displayed digits change only on the commit edge, never mid-conversion.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dig_c <= '0;
      dig_b <= '0;
      dig_a <= '0;
    end else if (commit) begin
      dig_c <= bcd[11:8];
      dig_b <= bcd[7:4];
      dig_a <= bcd[3:0];
    end
  end

  // Scan prescaler and digit index; free-running regardless of conversions.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= (scan_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Select anode and digit for the current scan slot.
  always_comb begin
    anode_nx = ANODE_UNITS;
    nib      = dig_a;
    blank    = 1'b0;
    case (scan_idx)
      2'd1: begin
        anode_nx = ANODE_TENS;
        nib      = dig_b;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (dig_c == 4'd0) && (dig_b == 4'd0);
`endif
      end
      2'd2: begin
        anode_nx = ANODE_HUNDREDS;
        nib      = dig_c;
`ifdef LEADING_ZERO_BLANK_EN
        blank    = (dig_c == 4'd0);
`endif
      end
      default: ;
    endcase
    seg_nx = blank ? SEG_BLANK : seg_code(nib);
  end

  // Registered pin drivers, one cycle behind the scan index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Displays  <= 8'hFF;
      Segmentos <= 8'hFF;
    end else begin
      Displays  <= anode_nx;
      Segmentos <= seg_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when computing expected segments.
module tb_display_scan_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Valor;
  logic       Valido;
  logic       Listo;
  logic       Ocupado;
  logic [7:0] Displays;
  logic [7:0] Segmentos;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.SCAN_DIV(4), .DATA_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Valor     (Valor),
    .Valido    (Valido),
    .Listo     (Listo),
    .Ocupado   (Ocupado),
    .Displays  (Displays),
    .Segmentos (Segmentos)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] slot_seg(input int slot, input int c, input int b, input int a);
    if (slot == 0) return exp_seg(a);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 1) return (c == 0 && b == 0) ? 8'hFF : exp_seg(b);
    return (c == 0) ? 8'hFF : exp_seg(c);
`else
    if (slot == 1) return exp_seg(b);
    return exp_seg(c);
`endif
  endfunction

  function automatic logic [7:0] slot_anode(input int slot);
    if (slot == 0) return 8'hFE;
    if (slot == 1) return 8'hFD;
    return 8'hFB;
  endfunction

  task automatic wait_slot(input string tag, input logic [7:0] an);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Displays == an) break;
    end
    chk({tag, "_anode"}, {24'b0, Displays}, {24'b0, an});
  endtask

  task automatic check_digits(input string tag, input int c, input int b, input int a);
    for (int s = 0; s < 3; s++) begin
      wait_slot(tag, slot_anode(s));
      chk($sformatf("%s_seg%0d", tag, s), {24'b0, Segmentos}, {24'b0, slot_seg(s, c, b, a)});
    end
  endtask

  // One-cycle Valido pulse; Valor is disturbed mid-flight to prove capture.
  task automatic send_one(input string tag, input logic [7:0] v);
    int low;
    chk({tag, "_ready"}, {31'b0, Listo}, 32'd1);
    Valor  = v;
    Valido = 1'b1;
    tick();
    Valido = 1'b0;
    chk({tag, "_busy"}, {31'b0, Ocupado}, 32'd1);
    low = 0;
    for (int i = 0; i < 30; i++) begin
      if (Listo) break;
      low++;
      if (low == 2) Valor = ~v;
      tick();
    end
    chk({tag, "_lat"}, low, 32'd9);
    chk({tag, "_idle"}, {31'b0, Ocupado}, 32'd0);
  endtask

  initial begin
    int n;
    int prev;
    int acc_at;
    Reset  = 1'b1;
    Valor  = 8'd0;
    Valido = 1'b0;
    repeat (3) tick();
    chk("rst_disp", {24'b0, Displays}, 32'hFF);
    chk("rst_seg", {24'b0, Segmentos}, 32'hFF);
    chk("rst_listo", {31'b0, Listo}, 32'd0);
    chk("rst_busy", {31'b0, Ocupado}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("idle_listo", {31'b0, Listo}, 32'd1);

    check_digits("idle", 0, 0, 0);

    // Slot length: enter FD at its first cycle, count its duration.
    wait_slot("per_fe", 8'hFE);
    wait_slot("per_fd", 8'hFD);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Displays != 8'hFD) break;
      n++;
    end
    chk("slot_len", n, 32'd4);
    chk("slot_next", {24'b0, Displays}, 32'hFB);

    send_one("v169", 8'd169);
    check_digits("v169", 1, 6, 9);

    send_one("v255", 8'd255);
    check_digits("v255", 2, 5, 5);

    send_one("v0", 8'd0);
    check_digits("v0", 0, 0, 0);

    // Back-to-back with Valido held: 25 accepted now, 49 ten edges later.
    Valor  = 8'd25;
    Valido = 1'b1;
    tick();
    Valor  = 8'd49;
    prev   = 0;
    acc_at = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (prev == 1 && !Listo) begin
        acc_at = k;
        chk("b2b_mid_seg", {24'b0, Segmentos},
            {24'b0, slot_seg((Displays == 8'hFE) ? 0 : (Displays == 8'hFD) ? 1 : 2, 0, 2, 5)});
        break;
      end
      prev = Listo ? 1 : 0;
    end
    Valido = 1'b0;
    chk("b2b_gap", acc_at, 32'd10);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (Listo) break;
      tick();
    end
    check_digits("b2b", 0, 4, 9);

    // Reset sampled at T4 of a conversion of 121.
    Valor  = 8'd121;
    Valido = 1'b1;
    tick();
    Valido = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    chk("mrst_disp", {24'b0, Displays}, 32'hFF);
    chk("mrst_seg", {24'b0, Segmentos}, 32'hFF);
    chk("mrst_busy", {31'b0, Ocupado}, 32'd0);
    Reset = 1'b0;
    repeat (12) tick();
    chk("mrst_listo", {31'b0, Listo}, 32'd1);
    check_digits("mrst", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
